alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
Shares one combinational 8-bit ALU (9-bit result, 4-bit opcode, select bit) between NREQ requesters using round-robin arbitration. Each requester uses a valid/ready handshake. The block latches the granted operands, drives the ALU for a programmable number of settle cycles, then captures the result. It returns the result on a single response channel tagged with the requester id, and flags illegal operations.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, response id width; must satisfy 2**IDW >= NREQ
EXEC_CYCLES, 1, cycles operands are held on the ALU before the result is sampled (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  8*NREQ  operand a; requester i uses bits [8i+7:8i]
req_b  in  8*NREQ  operand b, packed the same way
req_opr  in  4*NREQ  opcode, requester i uses bits [4i+3:4i]
req_sel  in  NREQ  select bit for buffer and shift ops
alu_a  out  8  registered operand to the ALU
alu_b  out  8  registered operand to the ALU
alu_opr  out  4  registered opcode to the ALU
alu_sel  out  1  registered select to the ALU
alu_out  in  9  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of the requester the response belongs to
rsp_data  out  9  result
rsp_err  out  1  illegal-operation flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=0, all alu_* outputs=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, exec counter=0, round-robin pointer=0.
- Reset mid-operation aborts any in-flight op silently; no response is produced for it.
- State IDLE:
  - Grant g = first i with req_valid[i]=1, searching from ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally, in this state only. All other req_ready bits are 0.
  - On handshake: latch that requester's a, b, opr, sel into alu_* and g into rsp_id; set ptr=(g+1) mod NREQ; go to EXEC.
  - No req_valid bit set: stay in IDLE, ptr unchanged.
- State EXEC:
  - alu_* held stable. Counter counts 1..EXEC_CYCLES.
  - On the cycle the counter equals EXEC_CYCLES: register rsp_data and rsp_err, go to RESP.
- State RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_err stable.
  - On rsp_valid & rsp_ready: go to IDLE, rsp_valid=0 the next cycle.
  - req_ready=0 throughout EXEC and RESP.
- Latency: handshake at cycle N gives rsp_valid high at N+1+EXEC_CYCLES. Best throughput is one op per EXEC_CYCLES+2 cycles.
- Error rule: opr=4'd3 with b=0, or opr in 14..15, gives rsp_err=1 and rsp_data=9'd0 instead of alu_out. Latency is unchanged.
- Otherwise rsp_data=alu_out exactly as sampled (all 9 bits, no truncation) and rsp_err=0.
- Requester protocol: req_valid and the payload must be held until req_ready. The scheduler never grants an index whose req_valid=0.
- Starvation bound: a held request is granted within NREQ-1 other grants.
- Simultaneous events: a new request arriving during RESP waits for IDLE. rsp_ready is ignored when rsp_valid=0.
- alu_* keep the last issued op after completion. They do not return to 0.

Test Plan:
- Reset then single op: req0 a=8'd200, b=8'd100, opr=0, EXEC_CYCLES=1.
  -> req_ready[0] pulses one cycle; rsp_valid two cycles later; rsp_data=9'd300, rsp_id=0, rsp_err=0.
- Round-robin fairness: req0 and req1 held valid continuously, rsp_ready=1.
  -> grants alternate 0,1,0,1; rsp_id alternates; no requester is granted twice in a row.
- Illegal ops:
  - opr=3, a=8'd50, b=0 -> rsp_err=1, rsp_data=0.
  - opr=4'd15 -> rsp_err=1, rsp_data=0.
  - opr=3, a=50, b=7 -> rsp_data=7, rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles, then 1 (a=8'hFF, b=8'h01, opr=6).
  -> rsp_valid, rsp_data=9'h001 and rsp_id stable across the stall; req_ready=0 throughout; exactly one response.
- Reset mid-op: rst_n low during EXEC, then release.
  -> all outputs 0 asynchronously; no rsp_valid for the aborted op; next grant starts from requester 0.
- EXEC_CYCLES=3 instance with an opr=2, a=15, b=17 request.
  -> alu_* stable for 3 cycles; rsp_data=9'd255, since alu_out is sampled on the third EXEC cycle.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between NREQ valid/ready
// requesters; returns tagged results on a single response channel.
module alu_req_scheduler #(
    parameter int NREQ        = 2,
    parameter int IDW         = 1,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]   req_opr,
    input  logic [NREQ-1:0]     req_sel,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_opr,
    output logic                alu_sel,
    input  logic [8:0]          alu_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [8:0]          rsp_data,
    output logic                rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES);

    state_t          state_r;
    logic [IDW-1:0]  ptr_r;
    logic [3:0]      cnt_r;
    logic [7:0]      alu_a_r;
    logic [7:0]      alu_b_r;
    logic [3:0]      alu_opr_r;
    logic            alu_sel_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [8:0]      rsp_data_r;
    logic            rsp_err_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [NREQ-1:0] grant_oh_s;
    logic [7:0]      grant_a_s;
    logic [7:0]      grant_b_s;
    logic [3:0]      grant_opr_s;
    logic            grant_sel_s;
    logic [IDW-1:0]  next_ptr_s;
    logic            illegal_s;
    int              dist_v;
    int              best_v;

    // Division by zero and the two reserved opcodes yield an error response
    function automatic logic op_illegal(input logic [3:0] opr, input logic [7:0] b);
        return ((opr == 4'd3) && (b == 8'd0)) || (opr >= 4'd14);
    endfunction

    // Round-robin pick: the valid requester closest to the pointer, going upwards
    always_comb begin
        grant_idx_s = '0;
        grant_a_s   = 8'd0;
        grant_b_s   = 8'd0;
        grant_opr_s = 4'd0;
        grant_sel_s = 1'b0;
        best_v      = NREQ;
        dist_v      = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_v = (i - int'(ptr_r) + NREQ) % NREQ;
            if (req_valid[i] && (dist_v < best_v)) begin
                best_v      = dist_v;
                grant_idx_s = IDW'(i);
                grant_a_s   = req_a[8*i +: 8];
                grant_b_s   = req_b[8*i +: 8];
                grant_opr_s = req_opr[4*i +: 4];
                grant_sel_s = req_sel[i];
            end else begin
                best_v = best_v;
            end
        end
        grant_found_s = (best_v < NREQ);
    end

    // One-hot ready, only offered while idle
    always_comb begin
        grant_oh_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh_s[i] = grant_found_s && (grant_idx_s == IDW'(i));
        end
        if (state_r == ST_IDLE) begin
            req_ready = grant_oh_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer successor of the current grant, wrapping at NREQ
    always_comb begin
        if (grant_idx_s == IDW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + IDW'(1);
        end
        illegal_s = op_illegal(alu_opr_r, alu_b_r);
    end

    // Scheduler state, operand latch and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            cnt_r       <= 4'd0;
            alu_a_r     <= 8'd0;
            alu_b_r     <= 8'd0;
            alu_opr_r   <= 4'd0;
            alu_sel_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 9'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        alu_a_r   <= grant_a_s;
                        alu_b_r   <= grant_b_s;
                        alu_opr_r <= grant_opr_s;
                        alu_sel_r <= grant_sel_s;
                        rsp_id_r  <= grant_idx_s;
                        ptr_r     <= next_ptr_s;
                        cnt_r     <= 4'd1;
                        state_r   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == EXEC_LAST) begin
                        rsp_err_r   <= illegal_s;
                        rsp_data_r  <= illegal_s ? 9'd0 : alu_out;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 4'd0;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    cnt_r       <= 4'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_opr   = alu_opr_r;
    assign alu_sel   = alu_sel_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: a 3-requester single-cycle instance driven by
// directed and random traffic against a transaction-level model, plus a 3-cycle instance.
module tb_alu_req_scheduler;

    localparam int EX1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance 1: NREQ=3, EXEC_CYCLES=1
    logic [2:0]  v1 = 3'b0, s1 = 3'b0, rdy1;
    logic [23:0] a1 = 24'd0, b1 = 24'd0;
    logic [11:0] o1 = 12'd0;
    logic [7:0]  alu_a1, alu_b1;
    logic [3:0]  alu_o1;
    logic        alu_s1, rspv1, err1;
    logic        rr1 = 1'b0;
    logic [8:0]  alu_out1, data1;
    logic [1:0]  id1;

    // instance 2: NREQ=2, EXEC_CYCLES=3
    logic [1:0]  v2 = 2'b0, s2 = 2'b0, rdy2;
    logic [15:0] a2 = 16'd0, b2 = 16'd0;
    logic [7:0]  o2 = 8'd0;
    logic [7:0]  alu_a2, alu_b2;
    logic [3:0]  alu_o2;
    logic        alu_s2, rspv2, err2;
    logic        rr2 = 1'b0;
    logic [8:0]  alu_out2, data2;
    logic [0:0]  id2;

    // Reference ALU used both to drive alu_out and to predict results
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, input logic sel);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: return prod[8:0];
            4'd3: return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
            4'd4: return {1'b0, a | b};
            4'd5: return {1'b0, a ^ b};
            4'd6: return {1'b0, a & b};
            4'd7: return sel ? {1'b0, a} : {1'b0, b};
            4'd8: return sel ? {a, 1'b0} : {2'b0, a[7:1]};
            default: return {1'b1, ~a};
        endcase
    endfunction

    assign alu_out1 = alu_f(alu_a1, alu_b1, alu_o1, alu_s1);
    assign alu_out2 = alu_f(alu_a2, alu_b2, alu_o2, alu_s2);

    alu_req_scheduler #(.NREQ(3), .IDW(2), .EXEC_CYCLES(EX1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_a(a1), .req_b(b1), .req_opr(o1), .req_sel(s1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_opr(alu_o1), .alu_sel(alu_s1),
        .alu_out(alu_out1), .rsp_valid(rspv1), .rsp_ready(rr1),
        .rsp_id(id1), .rsp_data(data1), .rsp_err(err1));

    alu_req_scheduler #(.NREQ(2), .IDW(1), .EXEC_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_opr(o2), .req_sel(s2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_opr(alu_o2), .alu_sel(alu_s2),
        .alu_out(alu_out2), .rsp_valid(rspv2), .rsp_ready(rr2),
        .rsp_id(id2), .rsp_data(data2), .rsp_err(err2));

    // requester-side state for instance 1
    bit         pv [3];
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [3:0] po [3];
    logic       ps [3];

    // transaction-level model of instance 1
    bit         m_busy = 0;
    int         m_wait = 0;
    int         m_ptr  = 0;
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic [3:0] m_o = 4'd0;
    logic       m_s = 1'b0;
    int         m_id = 0;
    logic [8:0] m_data = 9'd0;
    logic       m_err = 1'b0;
    int         n_rsp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] o, input logic s);
        pa[i] = a; pb[i] = b; po[i] = o; ps[i] = s; pv[i] = 1;
    endtask

    task automatic pack1();
        for (int i = 0; i < 3; i++) begin
            v1[i] = pv[i];
            a1[8*i +: 8] = pa[i];
            b1[8*i +: 8] = pb[i];
            o1[4*i +: 4] = po[i];
            s1[i] = ps[i];
        end
    endtask

    // One clock of instance 1: drive at negedge, compare, then advance the model
    task automatic cycle1(input bit rr);
        int g;
        bit ill;
        @(negedge clk);
        rr1 = rr;
        pack1();
        #1;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && pv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        check("req_ready", 32'(rdy1), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("rsp_valid", 32'(rspv1), 32'(m_busy && m_wait == 0));
        check("alu_a", 32'(alu_a1), 32'(m_a));
        check("alu_b", 32'(alu_b1), 32'(m_b));
        check("alu_opr", 32'(alu_o1), 32'(m_o));
        check("alu_sel", 32'(alu_s1), 32'(m_s));
        if (m_busy && m_wait == 0) begin
            check("rsp_id", 32'(id1), 32'(m_id));
            check("rsp_data", 32'(data1), 32'(m_data));
            check("rsp_err", 32'(err1), 32'(m_err));
        end
        @(posedge clk);
        if (g >= 0) begin
            ill = ((po[g] == 4'd3) && (pb[g] == 8'd0)) || (po[g] >= 4'd14);
            m_busy = 1; m_wait = EX1; m_ptr = (g + 1) % 3; m_id = g;
            m_a = pa[g]; m_b = pb[g]; m_o = po[g]; m_s = ps[g];
            m_err = ill;
            m_data = ill ? 9'd0 : alu_f(pa[g], pb[g], po[g], ps[g]);
            pv[g] = 0;
        end else if (m_busy) begin
            if (m_wait > 0) m_wait--;
            else if (rr) begin m_busy = 0; n_rsp++; end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_req(i, 8'd0, 8'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) pv[i] = 0;
        pack1();
        #2;
        check("reset_ready", 32'(rdy1), 32'd0);
        check("reset_alu", {alu_a1, alu_b1, alu_o1, 3'd0, alu_s1, 8'd0}, 32'd0);
        check("reset_rsp", {13'd0, rspv1, id1, data1, err1, 6'd0}, 32'd0);
        #10 rst_n = 1'b1;

        // single op: 200 + 100
        set_req(0, 8'd200, 8'd100, 4'd0, 1'b0);
        for (int c = 0; c < 5; c++) cycle1(1'b1);
        check("single_rsp_count", 32'(n_rsp), 32'd1);

        // fairness with two continuously requesting masters
        for (int c = 0; c < 18; c++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i]) set_req(i, 8'(10 * c + i), 8'(c + 1), 4'(c % 7), 1'(c));
            cycle1(1'b1);
        end
        for (int c = 0; c < 6; c++) cycle1(1'b1);

        // illegal / boundary ops
        set_req(0, 8'd50, 8'd0, 4'd3, 1'b0);
        for (int c = 0; c < 4; c++) cycle1(1'b1);
        set_req(2, 8'd9, 8'd4, 4'd15, 1'b0);
        for (int c = 0; c < 4; c++) cycle1(1'b1);
        set_req(1, 8'd50, 8'd7, 4'd3, 1'b0);
        for (int c = 0; c < 4; c++) cycle1(1'b1);

        // backpressure: response held for 5 stalled cycles
        set_req(1, 8'hFF, 8'h01, 4'd6, 1'b0);
        for (int c = 0; c < 2 + 5; c++) cycle1(1'b0);
        for (int c = 0; c < 3; c++) cycle1(1'b1);

        // reset in the middle of an op
        set_req(0, 8'd1, 8'd2, 4'd0, 1'b0);
        cycle1(1'b1);
        @(negedge clk);
        pack1();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_alu", {alu_a1, alu_b1, alu_o1, 3'd0, alu_s1, 8'd0}, 32'd0);
        check("midrst_rsp", {13'd0, rspv1, id1, data1, err1, 6'd0}, 32'd0);
        m_busy = 0; m_wait = 0; m_ptr = 0;
        m_a = 8'd0; m_b = 8'd0; m_o = 4'd0; m_s = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        set_req(1, 8'd3, 8'd4, 4'd1, 1'b0);
        set_req(0, 8'd5, 8'd6, 4'd0, 1'b0);
        for (int c = 0; c < 8; c++) cycle1(1'b1);

        // random traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(3, 0) == 0)
                    set_req(i, 8'($urandom), ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom),
                            4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
            end
            cycle1($urandom_range(3, 0) != 0);
        end

        // EXEC_CYCLES=3 instance: 15 * 17 sampled on the third exec cycle
        @(negedge clk);
        v2 = 2'b01; a2[7:0] = 8'd15; b2[7:0] = 8'd17; o2[3:0] = 4'd2; rr2 = 1'b0;
        #1 check("x3_ready", 32'(rdy2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        v2 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            check("x3_alu", {alu_a2, alu_b2, alu_o2, 3'd0, alu_s2, 8'd0}, {8'd15, 8'd17, 4'd2, 12'd0});
            check("x3_busy", {30'd0, rspv2, 1'b0} | 32'(rdy2), 32'd0);
            @(negedge clk);
        end
        check("x3_rsp_valid", 32'(rspv2), 32'd1);
        check("x3_rsp_data", 32'(data2), 32'd255);
        check("x3_rsp_id_err", {30'd0, id2, err2}, 32'd0);
        rr2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("x3_rsp_done", 32'(rspv2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
